multi_packet_config: RTL and testbench

- Register-file/control block that configures NUM_CH independent downstream packet generators from one AXI4-Lite register space.
- Sits between the axi4_lite_slave core (ASHI register-handler side) and a bank of packet generators.
- Adds per-channel status, abort, sticky done flags, a multi-channel synchronous start and a completion interrupt.

---
 rtl/multi_packet_config_pkg.sv | 30 +++
 rtl/packet_chan_regs.sv | 54 +++++
 rtl/multi_packet_config.sv | 244 ++++++++++++++++++++++++
 tb/tb_multi_packet_config.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_packet_config_pkg.sv
// Shared constants for the multi-channel packet generator register block.
// Response codes, register offsets and the version word.
package multi_packet_config_pkg;

   localparam int CH_STRIDE = 8;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam logic [2:0] R_PACKET_COUNT = 3'd0;
   localparam logic [2:0] R_PACKET_LEN   = 3'd1;
   localparam logic [2:0] R_IDLE_CYCLES  = 3'd2;
   localparam logic [2:0] R_INIT_VALUE   = 3'd3;
   localparam logic [2:0] R_STATUS       = 3'd4;
   localparam logic [2:0] R_CONTROL      = 3'd5;

   localparam logic [2:0] G_START_MASK = 3'd0;
   localparam logic [2:0] G_BUSY_MASK  = 3'd1;
   localparam logic [2:0] G_DONE_MASK  = 3'd2;
   localparam logic [2:0] G_IRQ_ENABLE = 3'd3;
   localparam logic [2:0] G_VERSION    = 3'd4;

   localparam logic [31:0] VERSION_BASE = 32'h0002_0000;

   function automatic logic [31:0] version_word(input int num_ch);
      return VERSION_BASE | 32'(num_ch);
   endfunction

endpackage

// File: rtl/packet_chan_regs.sv
// One generator channel: four config registers, sticky done flag
// and the busy falling-edge detector that sets it.
module packet_chan_regs #(
   parameter int LEN_W               = 16,
   parameter int DEFAULT_PACKET_LEN  = 256,
   parameter int DEFAULT_IDLE_CYCLES = 1,
   parameter int DEFAULT_INIT_VALUE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      wdata,
   input  logic             we_count,
   input  logic             we_len,
   input  logic             we_idle,
   input  logic             we_init,
   input  logic             clr_done,
   input  logic             busy,
   output logic [31:0]      packet_count,
   output logic [LEN_W-1:0] packet_len,
   output logic [15:0]      idle_cycles,
   output logic [15:0]      initial_value,
   output logic             done
);

   logic busy_d;

   // config registers; enables arrive already qualified by the decoder
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         packet_count  <= '0;
         packet_len    <= LEN_W'(DEFAULT_PACKET_LEN);
         idle_cycles   <= 16'(DEFAULT_IDLE_CYCLES);
         initial_value <= 16'(DEFAULT_INIT_VALUE);
      end else begin
         if (we_count) packet_count  <= wdata;
         if (we_len)   packet_len    <= wdata[LEN_W-1:0];
         if (we_idle)  idle_cycles   <= wdata[15:0];
         if (we_init)  initial_value <= wdata[15:0];
      end
   end

   // busy falling edge sets done; a set beats a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_d <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy_d <= busy;
         if (busy_d && !busy) done <= 1'b1;
         else if (clr_done)   done <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_packet_config.sv
// AXI4-Lite (ASHI side) register block driving NUM_CH packet generators.
// Adds status, abort, sticky done, synchronous multi-start and an irq.
module multi_packet_config
   import multi_packet_config_pkg::*;
#(
   parameter int NUM_CH              = 4,
   parameter int LEN_W               = 16,
   parameter int MAX_LEN             = 9600,
   parameter int DEFAULT_PACKET_LEN  = 256,
   parameter int DEFAULT_IDLE_CYCLES = 1,
   parameter int DEFAULT_INIT_VALUE  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             ashi_windx,
   input  logic [31:0]             ashi_wdata,
   input  logic                    ashi_write,
   output logic [1:0]              ashi_wresp,
   output logic                    ashi_widle,
   input  logic [31:0]             ashi_rindx,
   input  logic                    ashi_read,
   output logic [31:0]             ashi_rdata,
   output logic [1:0]              ashi_rresp,
   output logic                    ashi_ridle,
   output logic [NUM_CH*LEN_W-1:0] packet_len,
   output logic [NUM_CH*32-1:0]    packet_count,
   output logic [NUM_CH*16-1:0]    idle_cycles,
   output logic [NUM_CH*16-1:0]    initial_value,
   output logic [NUM_CH-1:0]       start,
   output logic [NUM_CH-1:0]       abort,
   input  logic [NUM_CH-1:0]       packet_gen_busy,
   output logic                    irq
);

   localparam int GBASE = NUM_CH * CH_STRIDE;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   logic [0:0] wstate;
   logic [0:0] rstate;

   logic [31:0]      cnt_a [NUM_CH];
   logic [LEN_W-1:0] len_a [NUM_CH];
   logic [15:0]      idl_a [NUM_CH];
   logic [15:0]      ini_a [NUM_CH];
   logic [NUM_CH-1:0] done;
   logic [NUM_CH-1:0] cnt_nz;
   logic [NUM_CH-1:0] irq_en;

   logic              wr_fire;
   logic              rd_fire;
   logic              len_ok;
   logic [2:0]        wreg;
   logic [2:0]        rreg;
   logic [31:0]       wch;
   logic [31:0]       rch;
   logic [NUM_CH-1:0] wr_cnt;
   logic [NUM_CH-1:0] wr_len;
   logic [NUM_CH-1:0] wr_idl;
   logic [NUM_CH-1:0] wr_ini;
   logic [NUM_CH-1:0] clr_n;
   logic [NUM_CH-1:0] start_n;
   logic [NUM_CH-1:0] abort_n;
   logic              irq_we;
   logic [1:0]        wresp_n;
   logic [31:0]       rdata_n;
   logic [1:0]        rresp_n;

   assign wr_fire = ashi_write && (wstate == S_IDLE);
   assign rd_fire = ashi_read && (rstate == S_IDLE);
   assign ashi_widle = !ashi_write && (wstate == S_IDLE);
   assign ashi_ridle = !ashi_read && (rstate == S_IDLE);

   assign wreg = ashi_windx[2:0];
   assign rreg = ashi_rindx[2:0];
   assign wch  = ashi_windx >> 3;
   assign rch  = ashi_rindx >> 3;

   assign len_ok = (ashi_wdata != '0)
                && (ashi_wdata <= 32'(MAX_LEN));

   assign irq = |(done & irq_en);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      packet_chan_regs #(
         .LEN_W               (LEN_W),
         .DEFAULT_PACKET_LEN  (DEFAULT_PACKET_LEN),
         .DEFAULT_IDLE_CYCLES (DEFAULT_IDLE_CYCLES),
         .DEFAULT_INIT_VALUE  (DEFAULT_INIT_VALUE)
      ) u_regs (
         .clk           (clk),
         .reset         (reset),
         .wdata         (ashi_wdata),
         .we_count      (wr_cnt[g]),
         .we_len        (wr_len[g]),
         .we_idle       (wr_idl[g]),
         .we_init       (wr_ini[g]),
         .clr_done      (clr_n[g]),
         .busy          (packet_gen_busy[g]),
         .packet_count  (cnt_a[g]),
         .packet_len    (len_a[g]),
         .idle_cycles   (idl_a[g]),
         .initial_value (ini_a[g]),
         .done          (done[g])
      );
      assign packet_count[g*32 +: 32]     = cnt_a[g];
      assign packet_len[g*LEN_W +: LEN_W] = len_a[g];
      assign idle_cycles[g*16 +: 16]      = idl_a[g];
      assign initial_value[g*16 +: 16]    = ini_a[g];
   end

   // channels that hold a runnable (nonzero) packet count
   always_comb begin
      cnt_nz = '0;
      for (int i = 0; i < NUM_CH; i++) cnt_nz[i] = |cnt_a[i];
   end

   // write decode: enables, pulses and response for the strobed access
   always_comb begin
      wr_cnt  = '0;
      wr_len  = '0;
      wr_idl  = '0;
      wr_ini  = '0;
      clr_n   = '0;
      start_n = '0;
      abort_n = '0;
      irq_we  = 1'b0;
      wresp_n = RESP_OKAY;
      if (wr_fire) begin
         if (ashi_windx < 32'(GBASE)) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (wch == 32'(i)) begin
                  unique case (1'b1)
                     (wreg <= R_INIT_VALUE): begin
                        if (packet_gen_busy[i]) begin
                           wresp_n = RESP_SLVERR;
                        end else if (wreg == R_PACKET_LEN && !len_ok) begin
                           wresp_n = RESP_SLVERR;
                        end else begin
                           wr_cnt[i]  = (wreg == R_PACKET_COUNT);
                           wr_len[i]  = (wreg == R_PACKET_LEN);
                           wr_idl[i]  = (wreg == R_IDLE_CYCLES);
                           wr_ini[i]  = (wreg == R_INIT_VALUE);
                           start_n[i] = (wreg == R_PACKET_COUNT)
                                     && (ashi_wdata != '0);
                        end
                     end
                     (wreg == R_CONTROL): begin
                        abort_n[i] = ashi_wdata[0];
                        clr_n[i]   = ashi_wdata[1];
                     end
                     default: wresp_n = RESP_DECERR;
                  endcase
               end
            end
         end else if (ashi_windx < 32'(GBASE + CH_STRIDE)) begin
            unique case (1'b1)
               (wreg == G_START_MASK):
                  start_n = ashi_wdata[NUM_CH-1:0] & cnt_nz & ~packet_gen_busy;
               (wreg == G_DONE_MASK):
                  clr_n = ashi_wdata[NUM_CH-1:0];
               (wreg == G_IRQ_ENABLE):
                  irq_we = 1'b1;
               default: wresp_n = RESP_DECERR;
            endcase
         end else begin
            wresp_n = RESP_DECERR;
         end
      end
   end

   // read mux: data and response for the strobed index
   always_comb begin
      rdata_n = '0;
      rresp_n = RESP_OKAY;
      if (ashi_rindx < 32'(GBASE)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (rch == 32'(i)) begin
               unique case (1'b1)
                  (rreg == R_PACKET_COUNT): rdata_n = cnt_a[i];
                  (rreg == R_PACKET_LEN):   rdata_n = 32'(len_a[i]);
                  (rreg == R_IDLE_CYCLES):  rdata_n = 32'(idl_a[i]);
                  (rreg == R_INIT_VALUE):   rdata_n = 32'(ini_a[i]);
                  (rreg == R_STATUS):
                     rdata_n = {30'd0, done[i], packet_gen_busy[i]};
                  default: rresp_n = RESP_DECERR;
               endcase
            end
         end
      end else if (ashi_rindx < 32'(GBASE + CH_STRIDE)) begin
         unique case (1'b1)
            (rreg == G_BUSY_MASK):  rdata_n = 32'(packet_gen_busy);
            (rreg == G_DONE_MASK):  rdata_n = 32'(done);
            (rreg == G_IRQ_ENABLE): rdata_n = 32'(irq_en);
            (rreg == G_VERSION):    rdata_n = version_word(NUM_CH);
            default: rresp_n = RESP_DECERR;
         endcase
      end else begin
         rresp_n = RESP_DECERR;
      end
   end

   // write handler: two-state FSM, response and one-cycle pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wstate     <= S_IDLE;
         ashi_wresp <= RESP_OKAY;
         start      <= '0;
         abort      <= '0;
      end else begin
         start <= start_n;
         abort <= abort_n;
         if (wr_fire) begin
            wstate     <= S_RESP;
            ashi_wresp <= wresp_n;
         end else begin
            wstate <= S_IDLE;
         end
      end
   end

   // interrupt enable register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       irq_en <= '0;
      else if (irq_we) irq_en <= ashi_wdata[NUM_CH-1:0];
   end

   // read handler: two-state FSM, data captured at the strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rstate     <= S_IDLE;
         ashi_rdata <= '0;
         ashi_rresp <= RESP_OKAY;
      end else if (rd_fire) begin
         rstate     <= S_RESP;
         ashi_rdata <= rdata_n;
         ashi_rresp <= rresp_n;
      end else begin
         rstate <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_multi_packet_config.sv
// Self-checking bench for multi_packet_config: directed plan steps
// followed by random accesses against a behavioural register model.
module tb_multi_packet_config;

   localparam int NUM_CH  = 4;
   localparam int LEN_W   = 16;
   localparam int MAX_LEN = 9600;
   localparam int GB      = NUM_CH * 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [31:0]             ashi_windx;
   logic [31:0]             ashi_wdata;
   logic                    ashi_write;
   logic [1:0]              ashi_wresp;
   logic                    ashi_widle;
   logic [31:0]             ashi_rindx;
   logic                    ashi_read;
   logic [31:0]             ashi_rdata;
   logic [1:0]              ashi_rresp;
   logic                    ashi_ridle;
   logic [NUM_CH*LEN_W-1:0] packet_len;
   logic [NUM_CH*32-1:0]    packet_count;
   logic [NUM_CH*16-1:0]    idle_cycles;
   logic [NUM_CH*16-1:0]    initial_value;
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       abort;
   logic [NUM_CH-1:0]       packet_gen_busy;
   logic                    irq;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   logic [31:0]       m_count [NUM_CH];
   logic [15:0]       m_len   [NUM_CH];
   logic [15:0]       m_idle  [NUM_CH];
   logic [15:0]       m_init  [NUM_CH];
   logic [NUM_CH-1:0] m_done;
   logic [NUM_CH-1:0] m_irqen;
   logic [NUM_CH-1:0] m_busy;

   multi_packet_config #(
      .NUM_CH  (NUM_CH),
      .LEN_W   (LEN_W),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ashi_windx      (ashi_windx),
      .ashi_wdata      (ashi_wdata),
      .ashi_write      (ashi_write),
      .ashi_wresp      (ashi_wresp),
      .ashi_widle      (ashi_widle),
      .ashi_rindx      (ashi_rindx),
      .ashi_read       (ashi_read),
      .ashi_rdata      (ashi_rdata),
      .ashi_rresp      (ashi_rresp),
      .ashi_ridle      (ashi_ridle),
      .packet_len      (packet_len),
      .packet_count    (packet_count),
      .idle_cycles     (idle_cycles),
      .initial_value   (initial_value),
      .start           (start),
      .abort           (abort),
      .packet_gen_busy (packet_gen_busy),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_count[i] = 0;
         m_len[i]   = 16'd256;
         m_idle[i]  = 16'd1;
         m_init[i]  = 16'd0;
      end
      m_done  = '0;
      m_irqen = '0;
   endtask

   // expected effect of one register write, from the register map rules
   task automatic model_write(input int idx, input logic [31:0] d,
                              input logic [NUM_CH-1:0] bz,
                              output logic [1:0] er,
                              output logic [NUM_CH-1:0] es,
                              output logic [NUM_CH-1:0] ea);
      int ch;
      int r;
      er = 2'd0;
      es = '0;
      ea = '0;
      ch = idx / 8;
      r  = idx % 8;
      if (idx < GB) begin
         if (r <= 3 && bz[ch]) er = 2'd2;
         else begin
            case (r)
               0: begin m_count[ch] = d; es[ch] = (d != 0); end
               1: if (d >= 1 && d <= MAX_LEN) m_len[ch] = d[15:0];
                  else er = 2'd2;
               2: m_idle[ch] = d[15:0];
               3: m_init[ch] = d[15:0];
               5: begin ea[ch] = d[0]; if (d[1]) m_done[ch] = 1'b0; end
               default: er = 2'd3;
            endcase
         end
      end else if (idx < GB + 8) begin
         case (r)
            0: for (int i = 0; i < NUM_CH; i++)
                  es[i] = d[i] && (m_count[i] != 0) && !bz[i];
            2: m_done = m_done & ~d[NUM_CH-1:0];
            3: m_irqen = d[NUM_CH-1:0];
            default: er = 2'd3;
         endcase
      end else begin
         er = 2'd3;
      end
      m_done = m_done | (m_busy & ~bz);
      m_busy = bz;
   endtask

   task automatic model_read(input int idx, output logic [31:0] ed,
                             output logic [1:0] er);
      int ch;
      int r;
      ed = 0;
      er = 2'd0;
      ch = idx / 8;
      r  = idx % 8;
      if (idx < GB) begin
         case (r)
            0: ed = m_count[ch];
            1: ed = {16'd0, m_len[ch]};
            2: ed = {16'd0, m_idle[ch]};
            3: ed = {16'd0, m_init[ch]};
            4: ed = {30'd0, m_done[ch], m_busy[ch]};
            default: er = 2'd3;
         endcase
      end else if (idx < GB + 8) begin
         case (r)
            1: ed = 32'(m_busy);
            2: ed = 32'(m_done);
            3: ed = 32'(m_irqen);
            4: ed = 32'h0002_0000 + NUM_CH;
            default: er = 2'd3;
         endcase
      end else begin
         er = 2'd3;
      end
   endtask

   task automatic wr(input int idx, input logic [31:0] d,
                     input logic [NUM_CH-1:0] bz, input string tag);
      logic [1:0]        er;
      logic [NUM_CH-1:0] es;
      logic [NUM_CH-1:0] ea;
      model_write(idx, d, bz, er, es, ea);
      @(negedge clk);
      ashi_windx      = 32'(idx);
      ashi_wdata      = d;
      ashi_write      = 1'b1;
      packet_gen_busy = bz;
      @(posedge clk);
      #1;
      ashi_write = 1'b0;
      chk({tag, ".wresp"}, 32'(ashi_wresp), 32'(er));
      chk({tag, ".start"}, 32'(start), 32'(es));
      chk({tag, ".abort"}, 32'(abort), 32'(ea));
      @(posedge clk);
      #1;
      chk({tag, ".start_once"}, 32'(start), 32'd0);
      chk({tag, ".abort_once"}, 32'(abort), 32'd0);
      chk({tag, ".widle"}, 32'(ashi_widle), 32'd1);
   endtask

   task automatic rd(input int idx, input string tag);
      logic [31:0] ed;
      logic [1:0]  er;
      int          n;
      model_read(idx, ed, er);
      @(negedge clk);
      ashi_rindx = 32'(idx);
      ashi_read  = 1'b1;
      @(posedge clk);
      #1;
      ashi_read = 1'b0;
      n = 0;
      while (!ashi_ridle && n < 4) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, ".ridle"}, 32'(ashi_ridle), 32'd1);
      chk({tag, ".rdata"}, ashi_rdata, ed);
      chk({tag, ".rresp"}, 32'(ashi_rresp), 32'(er));
   endtask

   task automatic chk_outputs(input string tag);
      for (int i = 0; i < NUM_CH; i++) begin
         chk({tag, ".count"}, packet_count[i*32 +: 32], m_count[i]);
         chk({tag, ".len"}, 32'(packet_len[i*LEN_W +: LEN_W]),
             32'(m_len[i]));
         chk({tag, ".idle"}, 32'(idle_cycles[i*16 +: 16]), 32'(m_idle[i]));
         chk({tag, ".init"}, 32'(initial_value[i*16 +: 16]),
             32'(m_init[i]));
      end
      chk({tag, ".irq"}, 32'(irq), 32'(|(m_done & m_irqen)));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".wresp"}, 32'(ashi_wresp), 32'd0);
      chk({tag, ".rresp"}, 32'(ashi_rresp), 32'd0);
      chk({tag, ".rdata"}, ashi_rdata, 32'd0);
      chk({tag, ".widle"}, 32'(ashi_widle), 32'd1);
      chk({tag, ".ridle"}, 32'(ashi_ridle), 32'd1);
      chk({tag, ".start"}, 32'(start), 32'd0);
      chk({tag, ".abort"}, 32'(abort), 32'd0);
   endtask

   initial begin
      int                idx;
      logic [31:0]       d;
      logic [NUM_CH-1:0] bz;

      reset           = 1'b1;
      ashi_windx      = '0;
      ashi_wdata      = '0;
      ashi_write      = 1'b0;
      ashi_rindx      = '0;
      ashi_read       = 1'b0;
      packet_gen_busy = '0;
      m_busy          = '0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("rst");
      chk_outputs("rst");
      reset = 1'b0;

      rd(2*8 + 1, "ch2_len");
      chk("ch2_len_256", ashi_rdata, 32'd256);
      rd(2*8 + 2, "ch2_idle");
      chk("ch2_idle_1", ashi_rdata, 32'd1);
      rd(GB + 4, "version");
      chk("version_lit", ashi_rdata, 32'h0002_0004);

      wr(1*8 + 1, 32'd9601, 4'b0000, "len_9601");
      chk("len_9601_slverr", 32'(ashi_wresp), 32'd2);
      rd(1*8 + 1, "len_kept");
      wr(1*8 + 1, 32'd9600, 4'b0000, "len_9600");
      chk("len_bus_9600", 32'(packet_len[31:16]), 32'd9600);
      wr(1*8 + 1, 32'd0, 4'b0000, "len_zero");

      wr(0, 32'd5, 4'b0000, "cnt0_5");
      wr(2, 32'd7, 4'b0001, "idle_busy");
      chk("idle_busy_slverr", 32'(ashi_wresp), 32'd2);
      rd(2, "idle_kept");

      wr(0, 32'd3, 4'b0000, "cnt0_3");
      wr(8, 32'd0, 4'b0000, "cnt1_0");
      wr(24, 32'd2, 4'b0000, "cnt3_2");
      wr(GB, 32'b1011, 4'b1000, "start_mask");
      chk("start_mask_only0", 32'(start), 32'd0);
      wr(GB, 32'd0, 4'b1000, "start_zero");

      wr(GB + 3, 32'b0100, 4'b1100, "irq_en");
      wr(GB + 3, 32'b0100, 4'b1000, "busy2_fall");
      chk("irq_after_fall", 32'(irq), 32'd1);
      rd(GB + 2, "done_mask");
      rd(2*8 + 4, "ch2_status");
      wr(GB + 3, 32'b0100, 4'b1100, "busy2_rise");
      wr(GB + 2, 32'b0100, 4'b1000, "w1c_vs_fall");
      rd(GB + 2, "done_kept");
      chk("done2_kept", 32'(ashi_rdata[2]), 32'd1);
      wr(GB + 2, 32'b0001, 4'b1000, "w1c_done0");
      rd(GB + 2, "done_cleared");

      wr(GB + 7, 32'hFFFF_FFFF, 4'b1000, "decerr");
      chk("decerr_lit", 32'(ashi_wresp), 32'd3);
      wr(GB + 1, 32'd1, 4'b1000, "ro_busy");
      rd(5, "ctrl_rd");
      rd(GB, "startmask_rd");
      wr(3*8 + 5, 32'd3, 4'b1000, "abort3");
      wr(2*8 + 3, 32'hABCD_1234, 4'b1000, "init_trunc");
      chk_outputs("dir");

      @(negedge clk);
      packet_gen_busy = '0;
      ashi_windx      = 32'(GB);
      ashi_wdata      = 32'hF;
      ashi_write      = 1'b1;
      @(posedge clk);
      #1;
      reset      = 1'b1;
      ashi_write = 1'b0;
      m_busy     = '0;
      m_reset();
      @(negedge clk);
      chk_reset_state("mid_rst");
      chk_outputs("mid_rst");
      @(negedge clk);
      reset = 1'b0;

      for (int t = 0; t < 300; t++) begin
         idx = int'($urandom_range(0, GB + 9));
         case ($urandom_range(0, 5))
            0: d = 32'd0;
            1: d = 32'($urandom_range(1, MAX_LEN));
            2: d = 32'(MAX_LEN);
            3: d = 32'(MAX_LEN + 1);
            default: d = $urandom;
         endcase
         bz = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : m_busy;
         if ($urandom_range(0, 1) == 1) wr(idx, d, bz, "rnd_w");
         else rd(idx, "rnd_r");
         if (t % 20 == 0) chk_outputs("rnd");
      end
      chk_outputs("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
